gc_multich_controller: RTL and testbench
========================================

Name: gc_multich_controller

Overview:
- Parametrised next-generation garbage-collection controller for the NVM block manager.
- Monitors per-channel clean-block counts for NUM_CH channels and arbitrates channels that need GC: urgent channels first, then round-robin.
- For the selected channel it runs the full clean cycle: victim request, per-page valid-data move loop, block erase, completion report.
- Sits between the free-block bookkeeping (clean counts, victim selection) and the channel command datapath (page move, erase).

Parameters:
- NUM_CH, 4, number of independent flash channels (>=1).
- CNT_W, 8, width of each per-channel clean-block count.
- BLK_W, 10, block-address width.
- PG_W, 6, page-index width; pages per block = 2**PG_W.
- GC_THRESH, 8, background GC is eligible when clean count < GC_THRESH.
- URGENT_THRESH, 1, urgent GC when clean count <= URGENT_THRESH; must be < GC_THRESH.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- gc_enable  in  1  permits background (non-urgent) GC
- clean_cnt  in  NUM_CH*CNT_W  packed per-channel clean counts; channel i at [i*CNT_W +: CNT_W]
- victim_req  out  1  request victim block for gc_ch
- victim_ack  in  1  victim_blk / victim_vcnt valid this cycle
- victim_blk  in  BLK_W  victim block address
- victim_vcnt  in  PG_W+1  number of valid pages in victim (0..2**PG_W)
- move_req  out  1  move valid page move_idx of clean_blk on gc_ch
- move_idx  out  PG_W  ordinal of valid page being moved
- move_done  in  1  current move completed
- erase_req  out  1  erase clean_blk on gc_ch
- erase_done  in  1  erase completed
- gc_ch  out  $clog2(NUM_CH) (min 1)  channel currently under GC
- clean_blk  out  BLK_W  latched victim block
- gc_busy  out  1  high in any state except IDLE
- gc_urgent  out  NUM_CH  combinational per-channel urgent flags
- gc_interrupt  out  1  OR of gc_urgent; host must throttle writes
- clean_done  out  1  one-cycle pulse, clean cycle finished

Behaviour:
- Reset: state IDLE; rr_ptr=0; gc_ch=0; clean_blk=0; vcnt/move_idx=0; all req outputs and clean_done low. Reset mid-operation abandons the cycle; no partial report.
- Eligibility: urgent[i] = clean_cnt_i <= URGENT_THRESH; bg[i] = gc_enable & (clean_cnt_i < GC_THRESH). If any urgent[i], arbitrate over urgent only; else over bg. Round-robin starting at rr_ptr, lowest index at/after rr_ptr wins, with wrap-around.
- States:
  - IDLE: if any eligible, latch winner into gc_ch, go VICTIM. victim_req rises the cycle after eligibility is seen.
  - VICTIM: victim_req=1 until victim_ack; on ack latch victim_blk->clean_blk, victim_vcnt->vcnt, move_idx=0. Go MOVE if vcnt!=0, else ERASE.
  - MOVE: move_req=1. On move_done: if move_idx==vcnt-1 go ERASE, else move_idx++ and stay; move_req stays high back-to-back. Width: compare in PG_W+1 bits; vcnt=2**PG_W is legal and move_idx never wraps.
  - ERASE: erase_req=1 until erase_done, then go DONE.
  - DONE: clean_done=1 for exactly one cycle; rr_ptr = gc_ch+1 mod NUM_CH; go IDLE. Next arbitration may start the following cycle.
- Handshakes: req outputs are Moore outputs of the state. A done/ack input is honoured only in its own state and ignored elsewhere. A done/ack in the first cycle of its state is accepted. gc_ch and clean_blk are stable from VICTIM exit through DONE.
- No preemption: a background cycle in progress completes even if another channel turns urgent. Arbitration ignores gc_enable falling mid-cycle.
- gc_interrupt is combinational and independent of state.
- NUM_CH=1: rr_ptr is a constant 0.

Decomposition:
- Package gc_pkg: gc_state_t enum (IDLE, VICTIM, MOVE, ERASE, DONE); default threshold localparams; a function to extract channel count i from the packed bus.
- Sub-module gc_rr_arbiter (params NUM_CH) with inputs req vector and rr_ptr, outputs grant_valid and grant_idx. Purely combinational; instantiated once, fed the urgent or bg vector.

Test Plan:
- Reset with all clean_cnt=20, gc_enable=1 -> stays IDLE, gc_busy=0, no reqs, gc_interrupt=0.
- ch2 clean_cnt=5, victim_ack with blk=0x3A5 and vcnt=3, move_done each cycle, erase_done after 4 cycles -> gc_ch=2, move_idx 0,1,2, erase_req held 4+ cycles, clean_done single pulse with clean_blk=0x3A5, next rr_ptr=3.
- ch0 and ch3 clean_cnt=5, ch1 clean_cnt=1, gc_enable=0 -> gc_urgent=4'b0010, gc_interrupt=1, ch1 served; afterwards ch0/ch3 not served until gc_enable=1.
- rr_ptr=3, ch0 and ch3 eligible -> ch3 first; after DONE with rr_ptr=0, ch0 next (wrap-around).
- vcnt=0 -> VICTIM goes directly to ERASE, no move_req; vcnt=64 (PG_W=6) -> 64 moves, last move_idx=63.
- nRST asserted during MOVE -> all outputs at reset values immediately; no clean_done; a fresh cycle starts after release.

Source files
------------

// File: rtl/gc_pkg.sv
// Shared types and helpers for the multi-channel garbage-collection controller.
package gc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VICTIM = 3'd1,
        MOVE   = 3'd2,
        ERASE  = 3'd3,
        DONE   = 3'd4
    } gc_state_t;

    localparam int unsigned DEF_GC_THRESH     = 8;
    localparam int unsigned DEF_URGENT_THRESH = 1;
    localparam int unsigned MAX_BUS_W         = 1024;

    // Channel idx's count from a packed bus of cnt_w-bit fields, zero-extended to 32 bits.
    function automatic logic [31:0] ch_cnt(input logic [MAX_BUS_W-1:0] bus,
                                           input int unsigned idx,
                                           input int unsigned cnt_w);
        logic [MAX_BUS_W-1:0] sh;
        logic [31:0]          mask;
        sh   = bus >> (idx * cnt_w);
        mask = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
        return sh[31:0] & mask;
    endfunction

endpackage

// File: rtl/gc_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after rr_ptr wins, with wrap.
module gc_rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic              grant_valid,
    output logic [CH_W-1:0]   grant_idx
);

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = int'(NUM_CH) - 1; off >= 0; off--) begin
            if (req[(int'(rr_ptr) + off) % int'(NUM_CH)]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'((int'(rr_ptr) + off) % int'(NUM_CH));
            end
        end
    end

endmodule

// File: rtl/gc_multich_controller.sv
// Multi-channel GC controller: picks a channel (urgent first, then round-robin background)
// and runs victim fetch, valid-page move loop, erase and completion report for it.
module gc_multich_controller
    import gc_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned BLK_W         = 10,
    parameter int unsigned PG_W          = 6,
    parameter int unsigned GC_THRESH     = DEF_GC_THRESH,
    parameter int unsigned URGENT_THRESH = DEF_URGENT_THRESH,
    localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    gc_enable,
    input  logic [NUM_CH*CNT_W-1:0] clean_cnt,
    output logic                    victim_req,
    input  logic                    victim_ack,
    input  logic [BLK_W-1:0]        victim_blk,
    input  logic [PG_W:0]           victim_vcnt,
    output logic                    move_req,
    output logic [PG_W-1:0]         move_idx,
    input  logic                    move_done,
    output logic                    erase_req,
    input  logic                    erase_done,
    output logic [CH_W-1:0]         gc_ch,
    output logic [BLK_W-1:0]        clean_blk,
    output logic                    gc_busy,
    output logic [NUM_CH-1:0]       gc_urgent,
    output logic                    gc_interrupt,
    output logic                    clean_done
);

    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0] CH_ONE   = CH_W'(1);
    localparam logic [PG_W:0]   VCNT_ONE = (PG_W+1)'(1);
    localparam logic [PG_W-1:0] IDX_ONE  = PG_W'(1);

    gc_state_t          state_q, state_d;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]    gc_ch_q, gc_ch_d;
    logic [BLK_W-1:0]   clean_blk_q, clean_blk_d;
    logic [PG_W:0]      vcnt_q, vcnt_d;
    logic [PG_W-1:0]    move_idx_q, move_idx_d;

    logic [MAX_BUS_W-1:0] cnt_bus;
    logic [NUM_CH-1:0]    urgent, bg, arb_req;
    logic                 grant_valid;
    logic [CH_W-1:0]      grant_idx;

    assign cnt_bus = MAX_BUS_W'(clean_cnt);

    always_comb begin
        urgent = '0;
        bg     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            urgent[i] = ch_cnt(cnt_bus, i, CNT_W) <= URGENT_THRESH;
            bg[i]     = gc_enable & (ch_cnt(cnt_bus, i, CNT_W) < GC_THRESH);
        end
    end

    // Any urgent channel shuts background candidates out of arbitration entirely.
    assign arb_req = (|urgent) ? urgent : bg;

    gc_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req         (arb_req),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gc_ch_d     = gc_ch_q;
        clean_blk_d = clean_blk_q;
        vcnt_d      = vcnt_q;
        move_idx_d  = move_idx_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    gc_ch_d = grant_idx;
                    state_d = VICTIM;
                end
            end
            VICTIM: begin
                if (victim_ack) begin
                    clean_blk_d = victim_blk;
                    vcnt_d      = victim_vcnt;
                    move_idx_d  = '0;
                    state_d     = (victim_vcnt != '0) ? MOVE : ERASE;
                end
            end
            MOVE: begin
                // Compared one bit wider so a full block of 2**PG_W pages ends without wrapping.
                if (move_done) begin
                    if ({1'b0, move_idx_q} == (vcnt_q - VCNT_ONE)) begin
                        state_d = ERASE;
                    end else begin
                        move_idx_d = move_idx_q + IDX_ONE;
                    end
                end
            end
            ERASE: begin
                if (erase_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rr_ptr_d = (gc_ch_q == CH_LAST) ? '0 : gc_ch_q + CH_ONE;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gc_ch_q     <= '0;
            clean_blk_q <= '0;
            vcnt_q      <= '0;
            move_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gc_ch_q     <= gc_ch_d;
            clean_blk_q <= clean_blk_d;
            vcnt_q      <= vcnt_d;
            move_idx_q  <= move_idx_d;
        end
    end

    assign victim_req   = (state_q == VICTIM);
    assign move_req     = (state_q == MOVE);
    assign erase_req    = (state_q == ERASE);
    assign clean_done   = (state_q == DONE);
    assign gc_busy      = (state_q != IDLE);
    assign gc_ch        = gc_ch_q;
    assign clean_blk    = clean_blk_q;
    assign move_idx     = move_idx_q;
    assign gc_urgent    = urgent;
    assign gc_interrupt = |urgent;

endmodule

// File: tb/tb_gc_multich_controller.sv
// Bench for gc_multich_controller: urgent-flag table, directed clean cycles, and randomized
// cycles checked against a round-robin channel-selection model.
module tb_gc_multich_controller;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        gc_enable;
    logic [31:0] clean_cnt;
    logic        victim_req;
    logic        victim_ack;
    logic [9:0]  victim_blk;
    logic [6:0]  victim_vcnt;
    logic        move_req;
    logic [5:0]  move_idx;
    logic        move_done;
    logic        erase_req;
    logic        erase_done;
    logic [1:0]  gc_ch;
    logic [9:0]  clean_blk;
    logic        gc_busy;
    logic [3:0]  gc_urgent;
    logic        gc_interrupt;
    logic        clean_done;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int model_rr = 0;

    gc_multich_controller #(
        .NUM_CH(4), .CNT_W(8), .BLK_W(10), .PG_W(6), .GC_THRESH(8), .URGENT_THRESH(1)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .gc_enable    (gc_enable),
        .clean_cnt    (clean_cnt),
        .victim_req   (victim_req),
        .victim_ack   (victim_ack),
        .victim_blk   (victim_blk),
        .victim_vcnt  (victim_vcnt),
        .move_req     (move_req),
        .move_idx     (move_idx),
        .move_done    (move_done),
        .erase_req    (erase_req),
        .erase_done   (erase_done),
        .gc_ch        (gc_ch),
        .clean_blk    (clean_blk),
        .gc_busy      (gc_busy),
        .gc_urgent    (gc_urgent),
        .gc_interrupt (gc_interrupt),
        .clean_done   (clean_done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
        $fatal(1);
    end

    typedef struct {
        logic [31:0] cnt;
        logic        en;
        logic [3:0]  urg;
        logic        intr;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] pack(input logic [7:0] c3, input logic [7:0] c2,
                                         input logic [7:0] c1, input logic [7:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    // Selection model: urgent set if non-empty, else background set; pick nearest at/after rr.
    function automatic int model_pick(input logic [31:0] cnt, input bit en, input int rr);
        int  best;
        int  bestd;
        bit  anyu;
        int  c;
        bit  elig;
        best  = -1;
        bestd = 99;
        anyu  = 0;
        for (int i = 0; i < 4; i++) if (int'(cnt[i*8 +: 8]) <= 1) anyu = 1;
        for (int i = 0; i < 4; i++) begin
            c    = int'(cnt[i*8 +: 8]);
            elig = anyu ? (c <= 1) : (en && c < 8);
            if (elig && ((i - rr + 4) % 4) < bestd) begin
                bestd = (i - rr + 4) % 4;
                best  = i;
            end
        end
        return best;
    endfunction

    function automatic logic [3:0] model_urg(input logic [31:0] cnt);
        logic [3:0] u;
        for (int i = 0; i < 4; i++) u[i] = (int'(cnt[i*8 +: 8]) <= 1);
        return u;
    endfunction

    // Drive one full clean cycle as the surrounding datapath and check every observable step.
    task automatic run_cycle(input string tag, input int exp_ch, input logic [9:0] blk,
                             input int vcnt, input int erase_dly, input bit rnd,
                             input logic [31:0] next_cnt, output int lat);
        int w;
        int d;
        w = 0;
        while (!victim_req && w < 12) begin
            step();
            w++;
        end
        lat = w;
        chk({tag, "_victim_req"}, 64'(victim_req), 64'(1));
        if (!victim_req) return;
        chk({tag, "_gc_ch"}, 64'(gc_ch), 64'(exp_ch));
        chk({tag, "_busy"}, 64'(gc_busy), 64'(1));
        d = rnd ? int'($urandom_range(0, 3)) : 0;
        repeat (d) begin
            move_done  = 1'b1;
            erase_done = 1'b1;
            step();
        end
        move_done   = 1'b0;
        erase_done  = 1'b0;
        victim_ack  = 1'b1;
        victim_blk  = blk;
        victim_vcnt = 7'(vcnt);
        step();
        victim_ack  = 1'b0;
        victim_blk  = 10'($urandom);
        victim_vcnt = 7'($urandom);
        clean_cnt   = next_cnt;
        if (vcnt == 0) chk({tag, "_vcnt0_skip"}, 64'({move_req, erase_req}), 64'(2'b01));
        for (int k = 0; k < vcnt; k++) begin
            chk({tag, "_move_req"}, 64'(move_req), 64'(1));
            chk({tag, "_move_idx"}, 64'(move_idx), 64'(k));
            d = rnd ? int'($urandom_range(0, 2)) : 0;
            repeat (d) begin
                erase_done = 1'b1;
                victim_ack = 1'b1;
                step();
            end
            erase_done = 1'b0;
            victim_ack = 1'b0;
            move_done  = 1'b1;
            step();
            move_done  = 1'b0;
        end
        chk({tag, "_erase_entry"}, 64'({move_req, erase_req}), 64'(2'b01));
        d = rnd ? int'($urandom_range(0, 4)) : erase_dly;
        repeat (d) begin
            chk({tag, "_erase_hold"}, 64'(erase_req), 64'(1));
            move_done  = 1'b1;
            victim_ack = 1'b1;
            step();
        end
        move_done  = 1'b0;
        victim_ack = 1'b0;
        erase_done = 1'b1;
        step();
        erase_done = 1'b0;
        chk({tag, "_clean_done"}, 64'(clean_done), 64'(1));
        chk({tag, "_clean_blk"}, 64'(clean_blk), 64'(blk));
        chk({tag, "_gc_ch_done"}, 64'(gc_ch), 64'(exp_ch));
        chk({tag, "_erase_off"}, 64'(erase_req), 64'(0));
        step();
        chk({tag, "_done_pulse"}, 64'(clean_done), 64'(0));
        chk({tag, "_idle"}, 64'(gc_busy), 64'(0));
        model_rr = (exp_ch + 1) % 4;
    endtask

    localparam logic [31:0] ALL20 = {8'd20, 8'd20, 8'd20, 8'd20};

    initial begin
        vec_t tbl[6];
        int   lat;
        int   w;
        int   exp_ch;
        int   vc;
        int   r;
        logic [7:0] cv [4];

        tbl[0] = '{ALL20,                              1'b1, 4'b0000, 1'b0};
        tbl[1] = '{{8'd0,   8'd1,   8'd2,   8'd255},   1'b1, 4'b1100, 1'b1};
        tbl[2] = '{{8'd2,   8'd2,   8'd2,   8'd2},     1'b1, 4'b0000, 1'b0};
        tbl[3] = '{{8'd1,   8'd20,  8'd1,   8'd20},    1'b0, 4'b1010, 1'b1};
        tbl[4] = '{{8'd255, 8'd255, 8'd255, 8'd0},     1'b0, 4'b0001, 1'b1};
        tbl[5] = '{{8'd7,   8'd8,   8'd1,   8'd9},     1'b1, 4'b0010, 1'b1};

        nRST        = 1'b0;
        gc_enable   = 1'b1;
        clean_cnt   = ALL20;
        victim_ack  = 1'b0;
        victim_blk  = '0;
        victim_vcnt = '0;
        move_done   = 1'b0;
        erase_done  = 1'b0;

        // Urgent flags are combinational; exercised while reset holds the FSM in IDLE.
        for (int i = 0; i < 6; i++) begin
            clean_cnt = tbl[i].cnt;
            gc_enable = tbl[i].en;
            #1;
            chk("tbl_urgent", 64'(gc_urgent), 64'(tbl[i].urg));
            chk("tbl_interrupt", 64'(gc_interrupt), 64'(tbl[i].intr));
            chk("tbl_busy_in_reset", 64'(gc_busy), 64'(0));
        end

        clean_cnt = ALL20;
        gc_enable = 1'b1;
        step();
        step();
        nRST = 1'b1;
        repeat (5) step();
        chk("reset_busy", 64'(gc_busy), 64'(0));
        chk("reset_reqs", 64'({victim_req, move_req, erase_req, clean_done}), 64'(0));
        chk("reset_irq", 64'(gc_interrupt), 64'(0));
        chk("reset_outs", 64'({gc_ch, clean_blk, move_idx}), 64'(0));

        clean_cnt = pack(8'd20, 8'd5, 8'd20, 8'd20);
        run_cycle("ch2", 2, 10'h3A5, 3, 4, 1'b0, ALL20, lat);
        chk("ch2_latency", 64'(lat), 64'(1));

        clean_cnt = pack(8'd5, 8'd20, 8'd20, 8'd5);
        run_cycle("rr3", 3, 10'h111, 1, 0, 1'b0, pack(8'd20, 8'd20, 8'd20, 8'd5), lat);
        run_cycle("wrap0", 0, 10'h222, 2, 1, 1'b0, ALL20, lat);

        clean_cnt = pack(8'd5, 8'd20, 8'd1, 8'd5);
        gc_enable = 1'b0;
        #1;
        chk("urg_flags", 64'(gc_urgent), 64'(4'b0010));
        chk("urg_irq", 64'(gc_interrupt), 64'(1));
        run_cycle("urg1", 1, 10'h0F0, 2, 1, 1'b0, pack(8'd5, 8'd20, 8'd20, 8'd5), lat);
        repeat (8) step();
        chk("bg_blocked_busy", 64'(gc_busy), 64'(0));
        chk("bg_blocked_req", 64'(victim_req), 64'(0));
        chk("bg_irq_clear", 64'(gc_interrupt), 64'(0));
        gc_enable = 1'b1;
        run_cycle("bg3", 3, 10'h333, 1, 0, 1'b0, pack(8'd20, 8'd20, 8'd20, 8'd5), lat);
        run_cycle("bg0", 0, 10'h044, 1, 0, 1'b0, ALL20, lat);

        clean_cnt = pack(8'd20, 8'd20, 8'd5, 8'd20);
        run_cycle("vcnt0", 1, 10'h2AA, 0, 2, 1'b0, ALL20, lat);

        clean_cnt = pack(8'd20, 8'd5, 8'd20, 8'd20);
        run_cycle("vcnt64", 2, 10'h3FF, 64, 0, 1'b0, ALL20, lat);

        // Reset in the middle of the move loop, then a fresh cycle from rr_ptr=0.
        clean_cnt = pack(8'd5, 8'd20, 8'd20, 8'd20);
        w = 0;
        while (!victim_req && w < 12) begin
            step();
            w++;
        end
        chk("rst_pre_gc_ch", 64'(gc_ch), 64'(3));
        victim_ack  = 1'b1;
        victim_blk  = 10'h155;
        victim_vcnt = 7'd5;
        step();
        victim_ack = 1'b0;
        move_done  = 1'b1;
        step();
        step();
        move_done = 1'b0;
        chk("rst_pre_move", 64'({move_req, move_idx}), 64'({1'b1, 6'd2}));
        clean_cnt = pack(8'd5, 8'd20, 8'd20, 8'd5);
        nRST = 1'b0;
        #1;
        chk("rst_async_reqs", 64'({victim_req, move_req, erase_req, clean_done, gc_busy}), 64'(0));
        chk("rst_async_regs", 64'({gc_ch, clean_blk, move_idx}), 64'(0));
        step();
        chk("rst_hold_done", 64'(clean_done), 64'(0));
        step();
        nRST = 1'b1;
        model_rr = 0;
        run_cycle("post_rst0", 0, 10'h0AB, 2, 0, 1'b0, pack(8'd5, 8'd20, 8'd20, 8'd20), lat);
        run_cycle("post_rst3", 3, 10'h0CD, 1, 0, 1'b0, ALL20, lat);

        for (int it = 0; it < 30; it++) begin
            for (int c = 0; c < 4; c++) begin
                r = int'($urandom_range(0, 9));
                if (r < 2)      cv[c] = 8'($urandom_range(0, 1));
                else if (r < 6) cv[c] = 8'($urandom_range(2, 7));
                else            cv[c] = 8'($urandom_range(8, 255));
            end
            clean_cnt = pack(cv[3], cv[2], cv[1], cv[0]);
            gc_enable = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_urgent", 64'(gc_urgent), 64'(model_urg(clean_cnt)));
            chk("rnd_irq", 64'(gc_interrupt), 64'(|model_urg(clean_cnt)));
            exp_ch = model_pick(clean_cnt, gc_enable, model_rr);
            if (exp_ch < 0) begin
                repeat (4) step();
                chk("rnd_none_busy", 64'(gc_busy), 64'(0));
            end else begin
                vc = ($urandom_range(0, 9) == 0) ? 64 : int'($urandom_range(0, 8));
                run_cycle("rnd", exp_ch, 10'($urandom), vc, 0, 1'b1, ALL20, lat);
                chk("rnd_latency", 64'(lat), 64'(1));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
